seq_divider: RTL and testbench
==============================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL have a parameter-free port list, fixed widths 64/32.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low; low forces reset state immediately, independent of clk.
REQ-004 start  input  1  request a division; sampled on rising clk edge.
REQ-005 dividend  input  64  signed two's-complement dividend; matches multiplier product width.
REQ-006 divisor  input  32  signed two's-complement divisor.
REQ-007 quotient  output  32  signed quotient, registered.
REQ-008 remainder  output  32  signed remainder, registered.
REQ-009 busy  output  1  high while a division is in progress.
REQ-010 done  output  1  one-cycle pulse marking valid results.
REQ-011 div_by_zero  output  1  registered flag; divisor was zero.
REQ-012 overflow  output  1  registered flag; true quotient not representable in 32-bit signed.

Function
REQ-013 The FSM SHALL have states IDLE, LOAD, DIVIDE, FIX; IDLE->LOAD on start, LOAD->DIVIDE, DIVIDE->FIX after 32 iterations, FIX->IDLE.
REQ-014 dividend and divisor SHALL be captured on the edge that accepts start; later input changes do not affect the operation.
REQ-015 start SHALL be accepted only in IDLE; start while busy is ignored, no queuing.
REQ-016 LOAD SHALL form unsigned magnitudes of both operands, record quotient sign (sign XOR) and remainder sign (dividend sign), and load a 5-bit iteration counter with 0.
REQ-017 DIVIDE SHALL perform one restoring shift-subtract step per cycle on a 33-bit partial remainder, producing one quotient bit MSB-first, 32 cycles exactly.
REQ-018 FIX SHALL apply signs: quotient negated if quotient sign set; remainder negated if dividend negative (truncate-toward-zero; |remainder| < |divisor|; dividend = quotient*divisor + remainder).
REQ-019 Latency SHALL be fixed at 34 rising edges from the start-accepting edge to done high, for every operand combination including zero and overflow cases.
REQ-020 busy SHALL be high from the edge after start acceptance through the FIX cycle; done SHALL be high exactly one cycle, while busy is low.
REQ-021 start asserted in the cycle done is high SHALL be accepted (back-to-back operation, 35-cycle throughput).
REQ-022 quotient, remainder and both flags SHALL update only at the FIX->IDLE edge and hold until the next done.
REQ-023 Divisor zero: quotient=0, remainder=dividend[31:0], div_by_zero=1, overflow=0.
REQ-024 Overflow: unsigned magnitude quotient >= 2^32 (upper 32 bits of |dividend| >= |divisor|), or magnitude > 2^31-1 with positive sign, or magnitude > 2^31 with negative sign; then quotient=0, remainder=0, overflow=1, div_by_zero=0.
REQ-025 Quotient exactly -2^31 SHALL be legal (overflow=0).
REQ-026 Dividend -2^63 SHALL be handled via 64-bit unsigned magnitude without error (reports overflow unless divisor magnitude is large enough to keep the quotient in range).

Reset
REQ-027 reset low SHALL drive state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, overflow=0, counter=0.
REQ-028 reset low mid-operation SHALL abort with no done pulse; first start after reset release starts a clean operation.
REQ-029 start is ignored while reset is low.

Verification
REQ-030 dividend=-35, divisor=5 -> done at edge 34, quotient=-7, remainder=0, flags 0; dividend=48, divisor=-4 -> quotient=-12, remainder=0.
REQ-031 dividend=7, divisor=-2 -> quotient=-3, remainder=1; dividend=-7, divisor=2 -> quotient=-3, remainder=-1; dividend=-7, divisor=-2 -> quotient=3, remainder=-1.
REQ-032 divisor=0, dividend=11 -> quotient=0, remainder=11, div_by_zero=1, done still at edge 34.
REQ-033 dividend=2^31, divisor=1 -> overflow=1, quotient=0; dividend=2^31, divisor=-1 -> quotient=-2^31, overflow=0; dividend=2^32, divisor=1 -> overflow=1.
REQ-034 start pulsed again at cycles 5 and 20 of an operation -> ignored, single done; start held high in the done cycle -> second result done exactly 35 edges after the first.
REQ-035 reset driven low at cycle 15 of an operation (asynchronously, mid-period) -> all outputs 0 immediately, no done; new start -> -9/5 yields quotient=-1, remainder=-4.

Source files
------------

// File: rtl/seq_divider.sv
// Sequential signed divider: 64-bit dividend by 32-bit divisor, restoring
// shift-subtract, one quotient bit per cycle, fixed 34-edge latency.
module seq_divider (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [63:0] dividend,
   input  logic [31:0] divisor,
   output logic [31:0] quotient,
   output logic [31:0] remainder,
   output logic        busy,
   output logic        done,
   output logic        div_by_zero,
   output logic        overflow
);

   typedef enum logic [1:0] {IDLE, LOAD, DIVIDE, FIX} state_t;

   state_t      state;
   logic [63:0] a_reg;
   logic [31:0] b_reg;
   logic [31:0] b_mag;
   logic [31:0] rem;
   logic [31:0] qsh;
   logic [4:0]  count;
   logic        q_sign;
   logic        r_sign;
   logic        zero_div;
   logic        big_quot;

   logic [63:0] a_mag;
   logic [31:0] b_abs;
   logic [32:0] shifted;
   logic [31:0] diff;
   logic        ge;
   logic [31:0] q_signed;
   logic [31:0] r_signed;
   logic        range_ovf;

   assign a_mag = a_reg[63] ? (~a_reg + 64'd1) : a_reg;
   assign b_abs = b_reg[31] ? (~b_reg + 32'd1) : b_reg;

   // 33-bit partial remainder; rem < b_mag keeps the true difference inside 32 bits
   assign shifted = {rem, qsh[31]};
   assign ge      = shifted >= {1'b0, b_mag};
   assign diff    = shifted[31:0] - b_mag;

   assign q_signed  = q_sign ? (~qsh + 32'd1) : qsh;
   assign r_signed  = r_sign ? (~rem + 32'd1) : rem;
   assign range_ovf = big_quot | (q_sign ? (qsh[31] & (|qsh[30:0])) : qsh[31]);

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values; blocking here would create order-dependent simulation.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         a_reg       <= '0;
         b_reg       <= '0;
         b_mag       <= '0;
         rem         <= '0;
         qsh         <= '0;
         count       <= '0;
         q_sign      <= 1'b0;
         r_sign      <= 1'b0;
         zero_div    <= 1'b0;
         big_quot    <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_reg <= dividend;
                  b_reg <= divisor;
                  busy  <= 1'b1;
                  state <= LOAD;
               end
            end
            LOAD: begin
               b_mag    <= b_abs;
               q_sign   <= a_reg[63] ^ b_reg[31];
               r_sign   <= a_reg[63];
               zero_div <= (b_reg == 32'd0);
               // a high half >= divisor means the quotient needs more than 32 bits
               big_quot <= (a_mag[63:32] >= b_abs);
               rem      <= a_mag[63:32];
               qsh      <= a_mag[31:0];
               count    <= 5'd0;
               state    <= DIVIDE;
            end
            DIVIDE: begin
               rem   <= ge ? diff : shifted[31:0];
               qsh   <= {qsh[30:0], ge};
               count <= count + 5'd1;
               if (count == 5'd31) state <= FIX;
            end
            FIX: begin
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= IDLE;
               if (zero_div) begin
                  quotient    <= '0;
                  remainder   <= a_reg[31:0];
                  div_by_zero <= 1'b1;
                  overflow    <= 1'b0;
               end else if (range_ovf) begin
                  quotient    <= '0;
                  remainder   <= '0;
                  div_by_zero <= 1'b0;
                  overflow    <= 1'b1;
               end else begin
                  quotient    <= q_signed;
                  remainder   <= r_signed;
                  div_by_zero <= 1'b0;
                  overflow    <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: driver pushes expected results, a
// negedge monitor pops and compares whenever done is presented.
module tb_seq_divider;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [63:0] dividend;
   logic [31:0] divisor;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        busy;
   logic        done;
   logic        div_by_zero;
   logic        overflow;

   seq_divider dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .quotient    (quotient),
      .remainder   (remainder),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      logic        dbz;
      logic        ovf;
      int          done_cyc;
   } exp_t;

   typedef struct {
      logic [63:0] a;
      logic [31:0] b;
      logic [31:0] q;
      logic [31:0] r;
      logic        dbz;
      logic        ovf;
   } vec_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (reset === 1'b1 && done === 1'b1) begin
         check("busy_low_at_done", busy, 64'd0);
         if (sb.size() == 0) begin
            check("unexpected_done", done, 64'd0);
         end else begin
            mon_e = sb.pop_front();
            check("latency",     cyc,         mon_e.done_cyc);
            check("quotient",    quotient,    mon_e.q);
            check("remainder",   remainder,   mon_e.r);
            check("div_by_zero", div_by_zero, mon_e.dbz);
            check("overflow",    overflow,    mon_e.ovf);
         end
      end
   end

   // Drives start at the current negedge, then pushes the expectation for the accepting edge.
   task automatic issue(input logic [63:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er,
                        input logic edbz, input logic eovf);
      exp_t e;
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clk);
      #1;
      e.q        = eq;
      e.r        = er;
      e.dbz      = edbz;
      e.ovf      = eovf;
      e.done_cyc = cyc + 34;
      sb.push_back(e);
      check("busy_after_accept", busy, 64'd1);
   endtask

   task automatic release_and_scramble();
      @(negedge clk);
      start    = 1'b0;
      dividend = {$urandom, $urandom};
      divisor  = $urandom;
   endtask

   task automatic drain();
      for (int i = 0; i < 80 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         check("drain_timeout", sb.size(), 64'd0);
         sb.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      vec_t vecs[14];
      vecs = '{
         '{-64'sd35,                 32'sd5,  32'hFFFF_FFF9, 32'h0000_0000, 1'b0, 1'b0},
         '{64'sd48,                  -32'sd4, 32'hFFFF_FFF4, 32'h0000_0000, 1'b0, 1'b0},
         '{64'sd7,                   -32'sd2, 32'hFFFF_FFFD, 32'h0000_0001, 1'b0, 1'b0},
         '{-64'sd7,                  32'sd2,  32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0},
         '{-64'sd7,                  -32'sd2, 32'h0000_0003, 32'hFFFF_FFFF, 1'b0, 1'b0},
         '{64'sd11,                  32'sd0,  32'h0000_0000, 32'h0000_000B, 1'b1, 1'b0},
         '{-64'sd11,                 32'sd0,  32'h0000_0000, 32'hFFFF_FFF5, 1'b1, 1'b0},
         '{64'h0000_0000_8000_0000,  32'sd1,  32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1},
         '{64'h0000_0000_8000_0000,  -32'sd1, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0},
         '{64'h0000_0001_0000_0000,  32'sd1,  32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1},
         '{64'h8000_0000_0000_0000,  32'sd5,  32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1},
         '{64'hFFFF_FFFF_8000_0000,  32'sd1,  32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0},
         '{64'hFFFF_FFFF_7FFF_FFFF,  32'sd1,  32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1},
         '{64'h0000_0001_0000_0000,  32'sd3,  32'h5555_5555, 32'h0000_0001, 1'b0, 1'b0}
      };

      reset    = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      #12;
      check("rst_quotient",  quotient,    64'd0);
      check("rst_remainder", remainder,   64'd0);
      check("rst_busy",      busy,        64'd0);
      check("rst_done",      done,        64'd0);
      check("rst_dbz",       div_by_zero, 64'd0);
      check("rst_ovf",       overflow,    64'd0);
      @(negedge clk);
      reset = 1'b1;

      foreach (vecs[i]) begin
         @(negedge clk);
         issue(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dbz, vecs[i].ovf);
         release_and_scramble();
         drain();
      end

      // Starts mid-operation must be dropped; the monitor flags any extra done.
      @(negedge clk);
      issue(64'sd1000, -32'sd3, 32'hFFFF_FEB3, 32'h0000_0001, 1'b0, 1'b0);
      release_and_scramble();
      for (int i = 2; i <= 25; i++) begin
         start    = (i == 5 || i == 20);
         dividend = 64'd5;
         divisor  = 32'd1;
         @(negedge clk);
      end
      start = 1'b0;
      drain();

      // Back-to-back: second start lands in the done cycle of the first.
      @(negedge clk);
      issue(64'sd100, 32'sd7, 32'd14, 32'd2, 1'b0, 1'b0);
      release_and_scramble();
      for (int i = 0; i < 60 && done !== 1'b1; i++) @(negedge clk);
      check("b2b_first_done_seen", done, 64'd1);
      issue(-64'sd100, 32'sd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0);
      release_and_scramble();
      drain();

      // Asynchronous reset mid-operation aborts without a done pulse.
      @(negedge clk);
      dividend = 64'd50;
      divisor  = 32'd5;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (14) @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      check("abort_quotient",  quotient,    64'd0);
      check("abort_remainder", remainder,   64'd0);
      check("abort_busy",      busy,        64'd0);
      check("abort_done",      done,        64'd0);
      check("abort_dbz",       div_by_zero, 64'd0);
      check("abort_ovf",       overflow,    64'd0);
      start = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("idle_after_reset", busy, 64'd0);
      issue(-64'sd9, 32'sd5, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 1'b0, 1'b0);
      release_and_scramble();
      drain();

      repeat (5) @(negedge clk);
      check("scoreboard_empty", sb.size(), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
